// File: rtl/sram_like_arbiter_nx1_if.sv
// sram_like_arbiter_nx1_if: NP-port sram-like bus with a shared read-data return.
interface sram_like_arbiter_nx1_if #(parameter int NP = 1);
  logic [NP-1:0]    req, wr, addr_ok, data_ok;
  logic [2*NP-1:0]  size;
  logic [32*NP-1:0] addr, wdata;
  logic [31:0]      rdata;
  modport master(output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave(input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/sram_like_arbiter_nx1.sv
// sram_like_arbiter_nx1: N-to-1 sram-like merger with in-order owner FIFO for responses.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module sram_like_arbiter_nx1 #(
  parameter int NUM_MASTERS = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  sram_like_arbiter_nx1_if.slave  m,
  sram_like_arbiter_nx1_if.master s
);
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] fifo [OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] lock_idx, win, grant, head;
  logic full, hs, pop;
`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;
  logic found;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++)
      if (!found && m.req[(int'(rr_ptr) + k) % NUM_MASTERS]) begin
        win = IDX_W'((int'(rr_ptr) + k) % NUM_MASTERS);
        found = 1'b1;
      end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) rr_ptr <= IDX_W'(NUM_MASTERS - 1);
    else if (hs) rr_ptr <= grant;
`else
  always_comb begin
    win = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--)
      if (m.req[k]) win = IDX_W'(k);
  end
`endif
  assign full = count == CNT_W'(OUTSTANDING);
  assign head = fifo[rd_ptr];
  assign pop  = s.data_ok[0] & (count != '0);
  assign hs   = s.req[0] & s.addr_ok[0];
  // Request gated by resetn so outputs drop the instant reset asserts.
  always_comb begin
    grant    = state == LOCK ? lock_idx : win;
    s.req[0] = (state == LOCK ? m.req[grant] : |m.req) & ~full & resetn;
    s.wr[0]  = m.wr[grant];
    s.size   = m.size[2*int'(grant) +: 2];
    s.addr   = m.addr[32*int'(grant) +: 32];
    s.wdata  = m.wdata[32*int'(grant) +: 32];
    m.addr_ok = hs ? NUM_MASTERS'(1) << grant : '0;
    m.data_ok = pop ? NUM_MASTERS'(1) << head : '0;
    m.rdata   = s.rdata;
    state_n   = state;
    if (state == IDLE && s.req[0] && !s.addr_ok[0]) state_n = LOCK;
    if (state == LOCK && hs) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state    <= IDLE;
      lock_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state  <= state_n;
      if (state == IDLE) lock_idx <= grant;
      wr_ptr <= wr_ptr + PTR_W'(hs);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(hs) - CNT_W'(pop);
    end
  always_ff @(posedge clk)
    if (hs) fifo[wr_ptr] <= grant;
endmodule
